// File: rtl/avr_trace_pkg.sv
// Shared trace types for the fetch-trace capture stage and the disassembler feeding from it.
// The record is packed at the widest program-address size so callers of any PAW can share it.
package avr_trace_pkg;

  typedef struct packed {
    logic [31:0] pc;
    logic [15:0] op0;
    logic [15:0] op1;
    logic        len;
  } trace_t;

  typedef enum logic {S_FIRST, S_SECOND} fsm_t;

  // lds (1001_000d) and sts (1001_001r) carry a 16-bit address word; jmp/call carry a target word
  function automatic bit is_two_word(bit [15:0] w);
    return ((w[15:10] == 6'b100100) && (w[3:0] == 4'b0000)) ||
           ((w[15:9] == 7'b1001010) && (w[3:2] == 2'b11));
  endfunction

endpackage

// File: rtl/avr_fetch_trace_if.sv
// Fetch-snoop bus from the core plus the valid/ready trace-record bus to the disassembler.
interface avr_fetch_trace_if #(parameter int PAW = 16);
  logic           fetch_vld;
  logic [PAW-1:0] fetch_adr;
  logic [15:0]    fetch_dat;
  logic           fetch_flush;
  logic           out_vld;
  logic           out_rdy;
  logic [PAW-1:0] out_pc;
  logic [15:0]    out_op0;
  logic [15:0]    out_op1;
  logic           out_len;

  modport master (
    output fetch_vld, fetch_adr, fetch_dat, fetch_flush, out_rdy,
    input  out_vld, out_pc, out_op0, out_op1, out_len
  );

  modport slave (
    input  fetch_vld, fetch_adr, fetch_dat, fetch_flush, out_rdy,
    output out_vld, out_pc, out_op0, out_op1, out_len
  );
endinterface

// File: rtl/avr_trace_fifo.sv
// Synchronous fall-through FIFO: the head entry is visible on dout whenever not empty, zero otherwise.
// A push into a full FIFO is still accepted when a pop frees the head slot in the same cycle.
module avr_trace_fifo #(
  parameter int W     = 49,
  parameter int DEPTH = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  logic                   pop,
  input  logic [W-1:0]           din,
  output logic [W-1:0]           dout,
  output logic                   empty,
  output logic                   push_ok,
  output logic [$clog2(DEPTH):0] count
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [W-1:0]  mem_q [DEPTH];
  logic [W-1:0]  mem_d [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          full;
  logic          do_pop;

  assign empty   = (count_q == '0);
  assign full    = (count_q == CW'(DEPTH));
  assign do_pop  = pop & ~empty;
  assign push_ok = push & (~full | do_pop);
  assign count   = count_q;
  assign dout    = empty ? '0 : mem_q[rd_ptr_q];

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_ok) begin
      mem_d[wr_ptr_q] = din;
      wr_ptr_d        = wr_ptr_q + AW'(1);
    end
    if (do_pop) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
    end
    case ({push_ok, do_pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset; only entries between the pointers are ever observed.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

endmodule

// File: rtl/avr_fetch_trace.sv
// Snoops the program-fetch bus, pairs two-word AVR instructions and queues {pc, op0, op1, len} records.
// Dropped records (FIFO full) and broken two-word sequences are counted with saturating counters.
module avr_fetch_trace
  import avr_trace_pkg::*;
#(
  parameter int PAW   = 16,
  parameter int DEPTH = 8,
  parameter int CNW   = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  avr_fetch_trace_if.slave       bus,
  output logic [$clog2(DEPTH):0] depth,
  output logic [CNW-1:0]         ovf_cnt,
  output logic [CNW-1:0]         err_cnt
);
  localparam int RW = PAW + 33;

  fsm_t           state_q, state_d;
  logic [PAW-1:0] pend_pc_q, pend_pc_d;
  logic [15:0]    pend_op_q, pend_op_d;
  logic [CNW-1:0] ovf_cnt_q, ovf_cnt_d;
  logic [CNW-1:0] err_cnt_q, err_cnt_d;
  logic           push, push_ok, pop, empty, err_inc, take_first;
  logic [RW-1:0]  rec, head;

  assign bus.out_vld = ~empty;
  assign pop         = bus.out_vld & bus.out_rdy;
  assign {bus.out_pc, bus.out_op0, bus.out_op1, bus.out_len} = head;
  assign ovf_cnt     = ovf_cnt_q;
  assign err_cnt     = err_cnt_q;

  avr_trace_fifo #(.W(RW), .DEPTH(DEPTH)) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push    (push),
    .pop     (pop),
    .din     (rec),
    .dout    (head),
    .empty   (empty),
    .push_ok (push_ok),
    .count   (depth)
  );

  // A flush behaves as if the FSM were already in S_FIRST when the current word is judged.
  always_comb begin
    state_d    = state_q;
    pend_pc_d  = pend_pc_q;
    pend_op_d  = pend_op_q;
    push       = 1'b0;
    rec        = '0;
    err_inc    = 1'b0;
    take_first = 1'b0;
    if (bus.fetch_flush) state_d = S_FIRST;
    if (bus.fetch_vld) begin
      take_first = 1'b1;
      if ((state_q == S_SECOND) && !bus.fetch_flush) begin
        if (bus.fetch_adr == pend_pc_q + PAW'(1)) begin
          push       = 1'b1;
          rec        = {pend_pc_q, pend_op_q, bus.fetch_dat, 1'b1};
          state_d    = S_FIRST;
          take_first = 1'b0;
        end else begin
          err_inc = 1'b1;
        end
      end
      if (take_first) begin
        if (is_two_word(bus.fetch_dat)) begin
          pend_pc_d = bus.fetch_adr;
          pend_op_d = bus.fetch_dat;
          state_d   = S_SECOND;
        end else begin
          push    = 1'b1;
          rec     = {bus.fetch_adr, bus.fetch_dat, 16'h0000, 1'b0};
          state_d = S_FIRST;
        end
      end
    end
  end

  always_comb begin
    ovf_cnt_d = ovf_cnt_q;
    err_cnt_d = err_cnt_q;
    if (push && !push_ok && (ovf_cnt_q != '1)) ovf_cnt_d = ovf_cnt_q + CNW'(1);
    if (err_inc && (err_cnt_q != '1))          err_cnt_d = err_cnt_q + CNW'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_FIRST;
      pend_pc_q <= '0;
      pend_op_q <= '0;
      ovf_cnt_q <= '0;
      err_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      pend_pc_q <= pend_pc_d;
      pend_op_q <= pend_op_d;
      ovf_cnt_q <= ovf_cnt_d;
      err_cnt_q <= err_cnt_d;
    end
  end

endmodule

// File: tb/tb_avr_fetch_trace.sv
// Scoreboard bench for avr_fetch_trace: expected records are queued as fetches are driven and
// compared, field by field and with their arrival cycle, when the DUT hands them out.
module tb_avr_fetch_trace;
  import avr_trace_pkg::*;

  localparam int PAW   = 16;
  localparam int DEPTH = 8;
  localparam int CNW   = 16;

  typedef struct {
    trace_t rec;
    int     due;
  } expEntry_t;

  logic                   clk = 1'b0;
  logic                   rst = 1'b1;
  logic [$clog2(DEPTH):0] depth;
  logic [CNW-1:0]         ovf_cnt;
  logic [CNW-1:0]         err_cnt;

  expEntry_t expq[$];
  expEntry_t curExp;
  int        cyc        = 0;
  int        checkCount = 0;
  int        passCount  = 0;
  int        failCount  = 0;

  avr_fetch_trace_if #(.PAW(PAW)) bus ();

  avr_fetch_trace #(.PAW(PAW), .DEPTH(DEPTH), .CNW(CNW)) dut (
    .clk     (clk),
    .rst     (rst),
    .bus     (bus.slave),
    .depth   (depth),
    .ovf_cnt (ovf_cnt),
    .err_cnt (err_cnt)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checkCount++;
    if (observed === expected) begin
      passCount++;
    end else begin
      failCount++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, observed, expected, cyc);
    end
  endtask

  // Drives one fetch-bus cycle just after a rising edge; the next edge consumes it.
  task automatic applyStimulus(input logic vld, input logic flush, input logic [15:0] adr, input logic [15:0] dat);
    @(posedge clk);
    #1;
    bus.fetch_vld   = vld;
    bus.fetch_flush = flush;
    bus.fetch_adr   = adr;
    bus.fetch_dat   = dat;
  endtask

  task automatic expectRec(input logic [31:0] pc, input logic [15:0] op0, input logic [15:0] op1,
                           input logic len, input int due);
    expEntry_t e;
    e.rec.pc  = pc;
    e.rec.op0 = op0;
    e.rec.op1 = op1;
    e.rec.len = len;
    e.due     = due;
    expq.push_back(e);
  endtask

  task automatic resetDut();
    @(posedge clk);
    #1;
    rst             = 1'b1;
    bus.fetch_vld   = 1'b0;
    bus.fetch_flush = 1'b0;
    expq.delete();
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic waitDrain(input string tag);
    for (int i = 0; i < 100; i++) begin
      @(posedge clk);
      #2;
      if (expq.size() == 0 && !bus.out_vld) break;
    end
    checkOutput({tag, "_left"}, 32'(expq.size()), 32'd0);
    checkOutput({tag, "_depth"}, 32'(depth), 32'd0);
  endtask

  // Scoreboard consumer: every handshake pops one expected record.
  always @(negedge clk) begin
    if (!rst && bus.out_vld && bus.out_rdy) begin
      if (expq.size() == 0) begin
        checkOutput("unexpected_rec", 32'(bus.out_pc), 32'hFFFF_FFFF);
      end else begin
        curExp = expq.pop_front();
        checkOutput("rec_pc",  32'(bus.out_pc),  curExp.rec.pc);
        checkOutput("rec_op0", 32'(bus.out_op0), 32'(curExp.rec.op0));
        checkOutput("rec_op1", 32'(bus.out_op1), 32'(curExp.rec.op1));
        checkOutput("rec_len", 32'(bus.out_len), 32'(curExp.rec.len));
        if (curExp.due >= 0) checkOutput("rec_cycle", 32'(cyc), 32'(curExp.due));
      end
    end
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    bus.fetch_vld   = 1'b0;
    bus.fetch_flush = 1'b0;
    bus.fetch_adr   = '0;
    bus.fetch_dat   = '0;
    bus.out_rdy     = 1'b1;

    resetDut();
    checkOutput("rst_out_vld", 32'(bus.out_vld), 32'd0);
    checkOutput("rst_out_pc",  32'(bus.out_pc),  32'd0);
    checkOutput("rst_out_op0", 32'(bus.out_op0), 32'd0);
    checkOutput("rst_out_op1", 32'(bus.out_op1), 32'd0);
    checkOutput("rst_out_len", 32'(bus.out_len), 32'd0);
    checkOutput("rst_depth",   32'(depth),       32'd0);
    checkOutput("rst_ovf",     32'(ovf_cnt),     32'd0);
    checkOutput("rst_err",     32'(err_cnt),     32'd0);

    $display("[TB] single-word stream");
    applyStimulus(1'b1, 1'b0, 16'h0010, 16'hEF0F);
    expectRec(32'h0010, 16'hEF0F, 16'h0000, 1'b0, cyc + 1);
    applyStimulus(1'b1, 1'b0, 16'h0011, 16'h2F01);
    expectRec(32'h0011, 16'h2F01, 16'h0000, 1'b0, cyc + 1);
    applyStimulus(1'b0, 1'b0, 16'h0000, 16'h0000);
    waitDrain("single");

    $display("[TB] two-word pair");
    resetDut();
    applyStimulus(1'b1, 1'b0, 16'h0020, 16'h940C);
    applyStimulus(1'b1, 1'b0, 16'h0021, 16'h0040);
    checkOutput("pair_first_no_rec", 32'(bus.out_vld), 32'd0);
    expectRec(32'h0020, 16'h940C, 16'h0040, 1'b1, cyc + 1);
    applyStimulus(1'b0, 1'b0, 16'h0000, 16'h0000);
    waitDrain("pair");
    checkOutput("pair_err", 32'(err_cnt), 32'd0);

    $display("[TB] broken pair");
    resetDut();
    applyStimulus(1'b1, 1'b0, 16'h0030, 16'h9300);
    applyStimulus(1'b1, 1'b0, 16'h0035, 16'hEF0F);
    expectRec(32'h0035, 16'hEF0F, 16'h0000, 1'b0, cyc + 1);
    applyStimulus(1'b0, 1'b0, 16'h0000, 16'h0000);
    checkOutput("broken_err", 32'(err_cnt), 32'd1);
    waitDrain("broken");

    $display("[TB] flush");
    resetDut();
    applyStimulus(1'b1, 1'b0, 16'h0040, 16'h940E);
    applyStimulus(1'b1, 1'b1, 16'h0050, 16'h0000);
    expectRec(32'h0050, 16'h0000, 16'h0000, 1'b0, cyc + 1);
    applyStimulus(1'b0, 1'b0, 16'h0000, 16'h0000);
    checkOutput("flush_err", 32'(err_cnt), 32'd0);
    waitDrain("flush");

    $display("[TB] address wrap");
    resetDut();
    applyStimulus(1'b1, 1'b0, 16'hFFFF, 16'h9200);
    applyStimulus(1'b1, 1'b0, 16'h0000, 16'h0100);
    expectRec(32'hFFFF, 16'h9200, 16'h0100, 1'b1, cyc + 1);
    applyStimulus(1'b0, 1'b0, 16'h0000, 16'h0000);
    checkOutput("wrap_err", 32'(err_cnt), 32'd0);
    waitDrain("wrap");

    $display("[TB] overflow");
    resetDut();
    bus.out_rdy = 1'b0;
    for (int i = 0; i < DEPTH + 3; i++) begin
      applyStimulus(1'b1, 1'b0, 16'h0100 + 16'(i), 16'h1000 + 16'(i));
      if (i < DEPTH) expectRec(32'h0100 + 32'(i), 16'h1000 + 16'(i), 16'h0000, 1'b0, -1);
    end
    applyStimulus(1'b0, 1'b0, 16'h0000, 16'h0000);
    checkOutput("ovf_depth",   32'(depth),       32'(DEPTH));
    checkOutput("ovf_cnt",     32'(ovf_cnt),     32'd3);
    checkOutput("ovf_head_pc", 32'(bus.out_pc),  32'h0100);
    applyStimulus(1'b0, 1'b0, 16'h0000, 16'h0000);
    checkOutput("ovf_hold_pc", 32'(bus.out_pc),  32'h0100);
    checkOutput("ovf_hold_op", 32'(bus.out_op0), 32'h1000);
    bus.out_rdy = 1'b1;
    waitDrain("ovf_drain");

    $display("[TB] reset while a second word is pending");
    bus.out_rdy = 1'b0;
    applyStimulus(1'b1, 1'b0, 16'h0058, 16'h2F01);
    applyStimulus(1'b1, 1'b0, 16'h0060, 16'h940C);
    applyStimulus(1'b0, 1'b0, 16'h0000, 16'h0000);
    checkOutput("pre_rst_vld", 32'(bus.out_vld), 32'd1);
    resetDut();
    checkOutput("mid_rst_vld",  32'(bus.out_vld), 32'd0);
    checkOutput("mid_rst_pc",   32'(bus.out_pc),  32'd0);
    checkOutput("mid_rst_op0",  32'(bus.out_op0), 32'd0);
    checkOutput("mid_rst_depth", 32'(depth),      32'd0);
    checkOutput("mid_rst_ovf",  32'(ovf_cnt),     32'd0);
    checkOutput("mid_rst_err",  32'(err_cnt),     32'd0);
    bus.out_rdy = 1'b1;
    applyStimulus(1'b1, 1'b0, 16'h0061, 16'h0001);
    expectRec(32'h0061, 16'h0001, 16'h0000, 1'b0, cyc + 1);
    applyStimulus(1'b0, 1'b0, 16'h0000, 16'h0000);
    checkOutput("post_rst_err", 32'(err_cnt), 32'd0);
    waitDrain("post_rst");

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
